id_ex_stage: RTL
================

# id_ex_stage

Decode-to-execute pipeline register of the RV32I core; sits directly upstream of the ALU. Captures decoded register/immediate operands under a valid/ready handshake, applies writeback forwarding, and presents registered `op_1`, `op_2` and the 4-bit ALU opcode (`{alt, funct3}`) plus destination info to the execute stage. Supports stall (downstream not ready) and flush (taken branch / trap).

## Interface
- `XLEN`, 32: datapath width.
- `clk_in`  input  1  clock; all state updates on rising edge.
- `reset_in`  input  1  synchronous, active-high reset.
- `id_valid_in`  input  1  decoder presents an instruction.
- `id_ready_out`  output  1  stage can accept this cycle.
- `id_rs1_addr_in`, `id_rs2_addr_in`  input  5  source register indices.
- `id_rs1_data_in`, `id_rs2_data_in`  input  XLEN  register-file read data.
- `id_imm_in`  input  XLEN  sign-extended immediate.
- `id_use_imm_in`  input  1  1 = OP-IMM (op_2 from immediate), 0 = OP.
- `id_funct3_in`  input  3  instruction funct3.
- `id_funct7b5_in`  input  1  instruction bit 30.
- `id_rd_addr_in`  input  5  destination register.
- `id_rd_wr_in`  input  1  instruction writes rd.
- `wb_wr_en_in`  input  1  writeback port writes this cycle.
- `wb_rd_addr_in`  input  5  writeback destination.
- `wb_data_in`  input  XLEN  writeback data.
- `flush_in`  input  1  discard held and incoming instruction.
- `ex_ready_in`  input  1  execute stage consumes this cycle.
- `ex_valid_out`  output  1  held instruction valid.
- `op_1_out`, `op_2_out`  output  XLEN  ALU operands.
- `opcode_out`  output  4  ALU opcode; [2:0] funct3, [3] sub/sra select.
- `rd_addr_out`  output  5  destination of held instruction.
- `rd_wr_out`  output  1  held instruction writes rd (forced 0 when rd = x0).

## Operation
- `id_ready_out = !ex_valid_out || ex_ready_in` (combinational, no dependence on `id_valid_in`).
- Per edge, priority: reset > flush > load > refresh > hold.
  - Flush: `ex_valid_out` <- 0; incoming instruction dropped; data registers may keep old values.
  - Load (`id_valid_in && id_ready_out`): capture all fields; `ex_valid_out` <- 1.
  - Consume without load (`ex_ready_in && ex_valid_out && !id_valid_in`): `ex_valid_out` <- 0.
  - Refresh while held and not consumed: any held register operand whose stored rs address equals `wb_rd_addr_in` with `wb_wr_en_in` and address != 0 is overwritten with `wb_data_in`.
- Forwarding on load: operand = `wb_data_in` if `wb_wr_en_in && wb_rd_addr_in == rsN && rsN != 0`, else `id_rsN_data_in`; rs = x0 always yields 0 regardless of read data.
- `op_2_out` = `id_imm_in` when `id_use_imm_in`; immediate operands are never refreshed.
- `opcode_out[3]`: OP -> `id_funct7b5_in` for funct3 000 and 101, else 0; OP-IMM -> `id_funct7b5_in` only for funct3 101 (SRAI), else 0 (ADDI never subtracts).
- `rd_wr_out` = `id_rd_wr_in && id_rd_addr_in != 0`.
- No arithmetic performed; all widths pass through unchanged.

## Timing
- Latency 1 cycle: accepted at edge N, visible on outputs after edge N.
- Full throughput: back-to-back accept every cycle while `ex_ready_in` = 1.
- Outputs stable while `ex_valid_out && !ex_ready_in`, except refresh updates.
- Flush same cycle as load: flush wins, `ex_valid_out` = 0 next cycle.
- Reset values: `ex_valid_out` 0, `op_1_out` 0, `op_2_out` 0, `opcode_out` 0, `rd_addr_out` 0, `rd_wr_out` 0; `id_ready_out` 1 from first cycle after reset.
- Reset asserted mid-stall clears held instruction; nothing reaches execute.

## Structure
- Shared package `riscv_pkg`: FUNCT3_* constants (ADD 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL 101, OR 110, AND 111), ALU opcode width 4, XLEN.
- One sub-module `fwd_mux`: compares rs address with writeback port, returns forwarded/zeroed operand; instantiated for rs1 and rs2, reused for load and refresh paths.

## Test plan
- Reset then ADD x3,x1,x2 with rs1=5, rs2=7, funct7b5=0 -> next cycle ex_valid=1, op_1=5, op_2=7, opcode=4'b0000, rd=3, rd_wr=1.
- SUB with same operands while wb writes x2=0x10 -> op_2=0x10, opcode=4'b1000.
- ADDI x1,x0,-1 with imm=0xFFFFFFFF, funct7b5=1, rs1 read data garbage 0xDEAD -> op_1=0, op_2=0xFFFFFFFF, opcode=4'b0000.
- SRAI imm=0x404 (funct7b5=1) -> opcode=4'b1101, op_2=0x404; SLLI same bit -> opcode=4'b0001.
- Stall: ex_ready=0 for 3 cycles, id_ready=0, outputs held; wb writes x1=0x55 in cycle 2 -> op_1 becomes 0x55; ex_ready=1 -> next instruction loads same cycle.
- Flush with id_valid=1 and held valid -> ex_valid=0 next cycle; write to rd=0 -> rd_wr=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width, ALU opcode width, funct3 encodings
// and the helper that forms the 4-bit ALU opcode {alt, funct3}.
package riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned FUNCT3_W = 3;

  localparam logic [FUNCT3_W-1:0] FUNCT3_ADD  = 3'b000;
  localparam logic [FUNCT3_W-1:0] FUNCT3_SLL  = 3'b001;
  localparam logic [FUNCT3_W-1:0] FUNCT3_SLT  = 3'b010;
  localparam logic [FUNCT3_W-1:0] FUNCT3_SLTU = 3'b011;
  localparam logic [FUNCT3_W-1:0] FUNCT3_XOR  = 3'b100;
  localparam logic [FUNCT3_W-1:0] FUNCT3_SRL  = 3'b101;
  localparam logic [FUNCT3_W-1:0] FUNCT3_OR   = 3'b110;
  localparam logic [FUNCT3_W-1:0] FUNCT3_AND  = 3'b111;

  // Bit 3 selects SUB/SRA. OP-IMM only honours it for SRAI, since ADDI
  // carries immediate bits in position 30 and must never subtract.
  function automatic logic [ALU_OP_W-1:0] alu_opcode(
    input logic [FUNCT3_W-1:0] funct3,
    input logic                funct7b5,
    input logic                use_imm
  );
    logic alt;
    if (use_imm) begin
      alt = funct7b5 && (funct3 == FUNCT3_SRL);
    end else begin
      alt = funct7b5 && ((funct3 == FUNCT3_ADD) || (funct3 == FUNCT3_SRL));
    end
    return {alt, funct3};
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Source operand select with writeback bypass.
// Ports: i-side rs address/data, writeback enable/address/data; o-side the
// operand (x0 reads as zero, a matching writeback overrides the read data).
module fwd_mux
  import riscv_pkg::*;
(
  input  logic [REG_AW-1:0] rs_addr_in,
  input  logic [XLEN-1:0]   rs_data_in,
  input  logic              wb_wr_en_in,
  input  logic [REG_AW-1:0] wb_rd_addr_in,
  input  logic [XLEN-1:0]   wb_data_in,
  output logic [XLEN-1:0]   op_c_out
);

  logic w_is_x0;
  logic w_hit;

  assign w_is_x0 = (rs_addr_in == REG_AW'(0));
  assign w_hit   = wb_wr_en_in && (wb_rd_addr_in == rs_addr_in);

  always_comb begin
    op_c_out = rs_data_in;
    if (w_is_x0) begin
      op_c_out = '0;
    end else if (w_hit) begin
      op_c_out = wb_data_in;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register. Accepts a decoded instruction under a
// valid/ready handshake, bypasses the writeback port into the source operands
// (both when loading and while stalled), and presents registered ALU operands,
// opcode and destination info to execute. Supports stall and flush.
// Ports: clk_in/reset_in (sync, active high); id_* decoder side with
// id_ready_out; wb_* writeback bypass; flush_in; ex_ready_in and the
// registered ex_valid_out, op_1_out, op_2_out, opcode_out, rd_addr_out,
// rd_wr_out toward execute.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                id_valid_in,
  output logic                id_ready_out,
  input  logic [REG_AW-1:0]   id_rs1_addr_in,
  input  logic [REG_AW-1:0]   id_rs2_addr_in,
  input  logic [XLEN-1:0]     id_rs1_data_in,
  input  logic [XLEN-1:0]     id_rs2_data_in,
  input  logic [XLEN-1:0]     id_imm_in,
  input  logic                id_use_imm_in,
  input  logic [FUNCT3_W-1:0] id_funct3_in,
  input  logic                id_funct7b5_in,
  input  logic [REG_AW-1:0]   id_rd_addr_in,
  input  logic                id_rd_wr_in,
  input  logic                wb_wr_en_in,
  input  logic [REG_AW-1:0]   wb_rd_addr_in,
  input  logic [XLEN-1:0]     wb_data_in,
  input  logic                flush_in,
  input  logic                ex_ready_in,
  output logic                ex_valid_out,
  output logic [XLEN-1:0]     op_1_out,
  output logic [XLEN-1:0]     op_2_out,
  output logic [ALU_OP_W-1:0] opcode_out,
  output logic [REG_AW-1:0]   rd_addr_out,
  output logic                rd_wr_out
);

  logic                r_ex_valid;
  logic [XLEN-1:0]     r_op_1;
  logic [XLEN-1:0]     r_op_2;
  logic [ALU_OP_W-1:0] r_opcode;
  logic [REG_AW-1:0]   r_rd_addr;
  logic                r_rd_wr;
  logic [REG_AW-1:0]   r_rs1_addr;
  logic [REG_AW-1:0]   r_rs2_addr;
  logic                r_use_imm;

  logic                w_id_ready;
  logic                w_load;
  logic [REG_AW-1:0]   w_rs1_addr;
  logic [REG_AW-1:0]   w_rs2_addr;
  logic [XLEN-1:0]     w_rs1_data;
  logic [XLEN-1:0]     w_rs2_data;
  logic [XLEN-1:0]     w_op_1;
  logic [XLEN-1:0]     w_op_2;

  assign w_id_ready = !r_ex_valid || ex_ready_in;
  assign w_load     = id_valid_in && w_id_ready;

  // One bypass mux per operand: fed from the decoder when loading, from the
  // held operand when refreshing a stalled instruction.
  assign w_rs1_addr = w_load ? id_rs1_addr_in : r_rs1_addr;
  assign w_rs2_addr = w_load ? id_rs2_addr_in : r_rs2_addr;
  assign w_rs1_data = w_load ? id_rs1_data_in : r_op_1;
  assign w_rs2_data = w_load ? id_rs2_data_in : r_op_2;

  fwd_mux u_fwd_rs1 (
    .rs_addr_in    (w_rs1_addr),
    .rs_data_in    (w_rs1_data),
    .wb_wr_en_in   (wb_wr_en_in),
    .wb_rd_addr_in (wb_rd_addr_in),
    .wb_data_in    (wb_data_in),
    .op_c_out      (w_op_1)
  );

  fwd_mux u_fwd_rs2 (
    .rs_addr_in    (w_rs2_addr),
    .rs_data_in    (w_rs2_data),
    .wb_wr_en_in   (wb_wr_en_in),
    .wb_rd_addr_in (wb_rd_addr_in),
    .wb_data_in    (wb_data_in),
    .op_c_out      (w_op_2)
  );

  // Pipeline register: reset > flush > load > consume > refresh > hold.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_ex_valid <= 1'b0;
      r_op_1     <= '0;
      r_op_2     <= '0;
      r_opcode   <= '0;
      r_rd_addr  <= '0;
      r_rd_wr    <= 1'b0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_use_imm  <= 1'b0;
    end else if (flush_in) begin
      r_ex_valid <= 1'b0;
    end else if (w_load) begin
      r_ex_valid <= 1'b1;
      r_op_1     <= w_op_1;
      r_op_2     <= id_use_imm_in ? id_imm_in : w_op_2;
      r_opcode   <= alu_opcode(id_funct3_in, id_funct7b5_in, id_use_imm_in);
      r_rd_addr  <= id_rd_addr_in;
      r_rd_wr    <= id_rd_wr_in && (id_rd_addr_in != REG_AW'(0));
      r_rs1_addr <= id_rs1_addr_in;
      r_rs2_addr <= id_rs2_addr_in;
      r_use_imm  <= id_use_imm_in;
    end else if (r_ex_valid && ex_ready_in) begin
      r_ex_valid <= 1'b0;
    end else if (r_ex_valid) begin
      // Stalled: pick up results written back after the operands were read.
      r_op_1 <= w_op_1;
      if (!r_use_imm) begin
        r_op_2 <= w_op_2;
      end
    end
  end

  assign id_ready_out = w_id_ready;
  assign ex_valid_out = r_ex_valid;
  assign op_1_out     = r_op_1;
  assign op_2_out     = r_op_2;
  assign opcode_out   = r_opcode;
  assign rd_addr_out  = r_rd_addr;
  assign rd_wr_out    = r_rd_wr;

endmodule
